// File: rtl/heartbeat_monitor.sv
// heartbeat_monitor: checks a peer heartbeat toggle against the 1 ms timebase and reports lock/loss status.
// Optional input deglitch filter is built in when HB_DEGLITCH_EN is defined.
module heartbeat_monitor #(
  parameter int U_DLY      = 1,
  parameter int TIMEOUT_MS = 1200,
  parameter int MIN_MS     = 300,
  parameter int LOCK_EDGES = 3,
  parameter int DG_CLKS    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ms_pulse,
  input  logic        hb_in,
  input  logic        clr_lost,
  output logic        alive,
  output logic        hb_lost,
  output logic        hb_err,
  output logic [10:0] hb_period,
  output logic [7:0]  lost_cnt
);
  typedef enum logic [1:0] {IDLE, LOCK, ALIVE, LOST} state_t;

  localparam logic [10:0] TIMEOUT_V = 11'(TIMEOUT_MS);
  localparam logic [10:0] MIN_V     = 11'(MIN_MS);
  localparam logic [3:0]  LOCK_V    = 4'(LOCK_EDGES);

  if (U_DLY < 0 || TIMEOUT_MS < 1 || TIMEOUT_MS > 2046 || MIN_MS >= TIMEOUT_MS ||
      LOCK_EDGES < 1 || LOCK_EDGES > 15 || DG_CLKS < 2 || DG_CLKS > 255) begin : g_param_chk
    $error("heartbeat_monitor: parameter out of range");
  end

  state_t      state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic [10:0] ms_cnt_q, ms_cnt_d;
  logic [10:0] hb_period_q, hb_period_d;
  logic [7:0]  lost_cnt_q, lost_cnt_d;
  logic        alive_q, alive_d, hb_lost_q, hb_lost_d, hb_err_q, hb_err_d;
  logic        sync1_q, hb_s_q, hb_d_q, hb_d_d, edge_det;
  logic        short_iv, legal, timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      hb_s_q  <= 1'b0;
      hb_d_q  <= 1'b0;
    end else begin
      sync1_q <= hb_in;
      hb_s_q  <= sync1_q;
      hb_d_q  <= hb_d_d;
    end
  end

`ifdef HB_DEGLITCH_EN
  logic [7:0] dg_cnt_q, dg_cnt_d;

  // Accepted level only follows hb_s after DG_CLKS consecutive differing clocks.
  always_comb begin
    dg_cnt_d = '0;
    hb_d_d   = hb_d_q;
    edge_det = 1'b0;
    if (hb_s_q != hb_d_q) begin
      if (dg_cnt_q == 8'(DG_CLKS)) begin
        edge_det = 1'b1;
        hb_d_d   = hb_s_q;
      end else begin
        dg_cnt_d = dg_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dg_cnt_q <= '0;
    else        dg_cnt_q <= dg_cnt_d;
  end
`else
  always_comb begin
    hb_d_d   = hb_s_q;
    edge_det = hb_s_q ^ hb_d_q;
  end
`endif

  // An edge restarts the interval and takes priority over a coincident ms_pulse.
  always_comb begin
    ms_cnt_d = ms_cnt_q;
    if (edge_det)                            ms_cnt_d = '0;
    else if (ms_pulse && ms_cnt_q != 11'h7FF) ms_cnt_d = ms_cnt_q + 11'd1;
  end

  assign short_iv = ms_cnt_q < MIN_V;
  assign legal    = !short_iv && (ms_cnt_q <= TIMEOUT_V);
  assign timeout  = ms_pulse && (ms_cnt_q == TIMEOUT_V) && !edge_det;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    unique case (state_q)
      IDLE: if (edge_det) begin
        state_d    = LOCK;
        good_cnt_d = '0;
      end
      LOCK: if (edge_det) begin
        if (legal) begin
          good_cnt_d = good_cnt_q + 4'd1;
          if (good_cnt_q + 4'd1 == LOCK_V) state_d = ALIVE;
        end else begin
          good_cnt_d = '0;
        end
      end else if (timeout) begin
        state_d = IDLE;
      end
      ALIVE: if (edge_det) begin
        if (!legal) begin
          state_d    = LOCK;
          good_cnt_d = '0;
        end
      end else if (timeout) begin
        state_d = LOST;
      end
      LOST: if (edge_det) begin
        state_d    = LOCK;
        good_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered status: the edge that leaves IDLE or LOST carries no valid interval.
  always_comb begin
    alive_d     = (state_d == ALIVE);
    hb_lost_d   = (state_q == ALIVE) && timeout;
    hb_err_d    = edge_det && short_iv && (state_q == LOCK || state_q == ALIVE);
    hb_period_d = hb_period_q;
    if (edge_det && (state_q == LOCK || state_q == ALIVE)) hb_period_d = ms_cnt_q;
    lost_cnt_d = lost_cnt_q;
    if (hb_lost_d)     lost_cnt_d = clr_lost ? 8'd1 :
                                    (lost_cnt_q == 8'hFF ? lost_cnt_q : lost_cnt_q + 8'd1);
    else if (clr_lost) lost_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt_q  <= '0;
      ms_cnt_q    <= '0;
      hb_period_q <= '0;
      lost_cnt_q  <= '0;
      alive_q     <= 1'b0;
      hb_lost_q   <= 1'b0;
      hb_err_q    <= 1'b0;
    end else begin
      good_cnt_q  <= good_cnt_d;
      ms_cnt_q    <= ms_cnt_d;
      hb_period_q <= hb_period_d;
      lost_cnt_q  <= lost_cnt_d;
      alive_q     <= alive_d;
      hb_lost_q   <= hb_lost_d;
      hb_err_q    <= hb_err_d;
    end
  end

  assign alive     = alive_q;
  assign hb_lost   = hb_lost_q;
  assign hb_err    = hb_err_q;
  assign hb_period = hb_period_q;
  assign lost_cnt  = lost_cnt_q;
endmodule

// File: tb/tb_heartbeat_monitor.sv
// Bench for heartbeat_monitor: randomized toggle/ms_pulse traffic against an interval-level reference model.
module tb_heartbeat_monitor;
  localparam int TO = 60;
  localparam int MN = 20;
  localparam int LE = 3;
  localparam int DG = 16;
  localparam int S_IDLE = 0, S_LOCK = 1, S_ALIVE = 2, S_LOST = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ms_pulse = 1'b0;
  logic        hb_in = 1'b0;
  logic        clr_lost = 1'b0;
  logic        alive, hb_lost, hb_err;
  logic [10:0] hb_period;
  logic [7:0]  lost_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: abstract monitor state and the ms elapsed since the last heartbeat edge.
  int m_state, m_good, m_cnt, m_period, m_lost;
  bit m_err, m_lostp;

  heartbeat_monitor #(
    .TIMEOUT_MS(TO), .MIN_MS(MN), .LOCK_EDGES(LE), .DG_CLKS(DG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ms_pulse(ms_pulse), .hb_in(hb_in), .clr_lost(clr_lost),
    .alive(alive), .hb_lost(hb_lost), .hb_err(hb_err), .hb_period(hb_period), .lost_cnt(lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".alive"},     int'(alive),     int'(m_state == S_ALIVE));
    chk({ctx, ".hb_lost"},   int'(hb_lost),   int'(m_lostp));
    chk({ctx, ".hb_err"},    int'(hb_err),    int'(m_err));
    chk({ctx, ".hb_period"}, int'(hb_period), m_period);
    chk({ctx, ".lost_cnt"},  int'(lost_cnt),  m_lost);
  endtask

  function automatic void model_reset();
    m_state = S_IDLE; m_good = 0; m_cnt = 0; m_period = 0; m_lost = 0;
    m_err = 0; m_lostp = 0;
  endfunction

  function automatic void model_pulse(input bit clr);
    m_err = 0; m_lostp = 0;
    if (m_cnt == TO && m_state == S_LOCK) m_state = S_IDLE;
    else if (m_cnt == TO && m_state == S_ALIVE) begin
      m_state = S_LOST;
      m_lostp = 1;
      m_lost  = clr ? 1 : (m_lost < 255 ? m_lost + 1 : 255);
    end
    if (!m_lostp && clr) m_lost = 0;
    if (m_cnt < 2047) m_cnt++;
  endfunction

  function automatic void model_edge();
    int  iv = m_cnt;
    bit  ok = (iv >= MN) && (iv <= TO);
    m_err = 0; m_lostp = 0;
    if (m_state == S_IDLE || m_state == S_LOST) begin
      m_state = S_LOCK; m_good = 0;
    end else begin
      m_period = iv;
      if (!ok) begin
        m_state = S_LOCK; m_good = 0; m_err = (iv < MN);
      end else if (m_state == S_LOCK) begin
        m_good++;
        if (m_good == LE) m_state = S_ALIVE;
      end
    end
    m_cnt = 0;
  endfunction

  task automatic step(input bit p, input bit c);
    ms_pulse = p;
    clr_lost = c;
    @(negedge clk);
    ms_pulse = 1'b0;
    clr_lost = 1'b0;
  endtask

  task automatic pulses(input int n, input bit clr_last);
    for (int i = 0; i < n; i++) begin
      bit c = clr_last && (i == n - 1);
      step(1'b1, c);
      model_pulse(c);
      check_all("pulse");
    end
  endtask

  // p=1 lands an ms_pulse in the same clock the edge is acted on.
  task automatic toggle(input bit p);
    hb_in = ~hb_in;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
`ifdef HB_DEGLITCH_EN
    repeat (DG) step(1'b0, 1'b0);
`endif
    step(p, 1'b0);
    model_edge();
    check_all("edge");
  endtask

  task automatic lock_up();
    toggle(1'b0);
    repeat (LE) begin
      pulses(25, 1'b0);
      toggle(1'b0);
    end
  endtask

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    check_all("post_reset");

    // Four toggles 30 ms apart: three legal intervals reach alive.
    toggle(1'b0);
    for (int k = 0; k < 3; k++) begin
      pulses(30, 1'b0);
      toggle(1'b0);
    end
    chk("t1.alive", int'(alive), 1);
    chk("t1.period", int'(hb_period), 30);

    // Edge coincident with the timeout-cycle ms_pulse: edge wins.
    pulses(TO, 1'b0);
    toggle(1'b1);
    chk("t5.alive", int'(alive), 1);
    chk("t5.period", int'(hb_period), TO);
    chk("t5.lost", int'(hb_lost), 0);

    // Short interval drops back to lock with an error pulse.
    pulses(10, 1'b0);
    toggle(1'b0);
    chk("t3.err", int'(hb_err), 1);
    chk("t3.alive", int'(alive), 0);
    chk("t3.period", int'(hb_period), 10);
    for (int k = 0; k < 3; k++) begin
      pulses(30, 1'b0);
      toggle(1'b0);
    end
    chk("t3.relock", int'(alive), 1);

    // Silence: loss fires on the ms_pulse after TO pulses.
    pulses(TO, 1'b0);
    chk("t2.still_alive", int'(alive), 1);
    pulses(1, 1'b0);
    chk("t2.lost_pulse", int'(hb_lost), 1);
    chk("t2.alive", int'(alive), 0);
    chk("t2.lost_cnt", int'(lost_cnt), 1);
    step(1'b0, 1'b0);
    m_lostp = 0;
    check_all("t2.after");

`ifdef HB_DEGLITCH_EN
    lock_up();
    hb_in = ~hb_in;
    repeat (10) step(1'b0, 1'b0);
    hb_in = ~hb_in;
    repeat (DG + 4) step(1'b0, 1'b0);
    m_err = 0; m_lostp = 0;
    check_all("glitch");
`endif

    // Random traffic: mixed intervals, occasional clears and coincident pulses.
    for (int r = 0; r < 40; r++) begin
      int n = $urandom_range(5, TO + 15);
      for (int i = 0; i < n; i++) begin
        bit c = ($urandom_range(0, 39) == 0);
        step(1'b1, c);
        model_pulse(c);
        check_all("rand.pulse");
      end
      toggle($urandom_range(0, 3) == 0);
    end

    // Drive lost_cnt to saturation.
    for (int k = 0; k < 300 && m_lost < 255; k++) begin
      lock_up();
      pulses(TO + 1, 1'b0);
    end
    chk("t4.at_max", int'(lost_cnt), 255);
    lock_up();
    pulses(TO + 1, 1'b0);
    chk("t4.sat", int'(lost_cnt), 255);
    lock_up();
    pulses(TO + 1, 1'b1);
    chk("t4.clr_with_loss", int'(lost_cnt), 1);
    step(1'b0, 1'b1);
    m_lost = 0; m_err = 0; m_lostp = 0;
    check_all("t4.clr_alone");

    // Asynchronous reset in the middle of alive operation.
    lock_up();
    pulses(7, 1'b0);
    #2;
    rst_n = 1'b0;
    hb_in = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    lock_up();
    chk("rst.relock", int'(alive), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
